dpram_frame_ctrl: RTL and testbench
===================================

// Module: dpram_frame_ctrl
// PURPOSE
//  Frame sequencer that drives both ports of the 8-bit dual-port RAM (dpram).
//  - Write side: accepts a byte stream (valid/ready) and writes FRAME_LEN bytes to addresses 0..FRAME_LEN-1.
//  - Read side: sweeps rdaddress 0..FRAME_LEN-1 and emits q as an output stream.
//  - Single buffer: writes and reads never overlap. Sits between the byte source and the downstream consumer.
// PARAMETERS
//  DATA_W    8   data width; matches the dpram data/q ports
//  ADDR_W    8   address width; matches dpram rdaddress/wraddress
//  FRAME_LEN 16  bytes per frame; legal range 1..2**ADDR_W
//  RD_LAT    1   clocks from rdaddress driven to valid q; legal range 1..3
// PORTS
//  Clk        in   1       system clock; the dpram uses the same clock
//  Rst_n      in   1       async active-low reset
//  in_data    in   DATA_W  input byte
//  in_valid   in   1       in_data is valid
//  in_ready   out  1       block can accept a byte (write phase only)
//  wraddress  out  ADDR_W  to dpram.wraddress
//  data       out  DATA_W  to dpram.data
//  wren       out  1       to dpram.wren
//  rdaddress  out  ADDR_W  to dpram.rdaddress
//  q          in   DATA_W  from dpram.q
//  out_data   out  DATA_W  read-back byte (equals q)
//  out_valid  out  1       out_data is valid; consumer cannot stall
//  frame_done out  1       1-cycle pulse when the read-out completes
//  out_sum    out  DATA_W  frame checksum (present only with the macro)
// BEHAVIOUR
//  Reset values: all outputs 0; state S_WR; wr_cnt=rd_cnt=0. in_ready rises on the first clock after reset release.
//  S_WR:
//   - in_ready=1. A byte is accepted when in_valid&in_ready at a rising edge.
//   - On accept, at the next cycle: wren=1, wraddress=wr_cnt, data=in_data. wr_cnt then increments.
//   - Gaps in in_valid are allowed; wren=0 while there is no accept.
//   - Accepting byte FRAME_LEN-1 moves to S_GAP; in_ready drops in the same edge.
//  S_GAP:
//   - Lasts 1 cycle; the final wren is high here.
//   - Guarantees no read-during-write on the same address (FRAME_LEN=1 case).
//  S_RD:
//   - in_ready=0; in_valid is ignored and nothing is written.
//   - rdaddress=rd_cnt, one new address per cycle, 0..FRAME_LEN-1, no gaps.
//   - After the last address: go to S_DRAIN, holding rdaddress at FRAME_LEN-1.
//  Read data path:
//   - out_valid is the per-address issue flag delayed RD_LAT cycles; out_data=q in that cycle.
//   - Result: FRAME_LEN consecutive valid cycles, in address order.
//  S_DRAIN:
//   - Waits until the delay line is empty.
//   - Then frame_done=1 for one cycle; wr_cnt and rd_cnt clear; return to S_WR.
//   - in_ready=1 in the cycle after frame_done.
//  Counters: wr_cnt and rd_cnt are ADDR_W+1 bits wide, so FRAME_LEN=2**ADDR_W has no wrap-around ambiguity.
//  Reset mid-operation: asynchronous return to reset values.
//   - A partly written frame is abandoned; RAM contents are undefined to the consumer.
//   - Any in-flight out_valid is killed immediately.
// CONFIGURATION
//  `define DPRAM_FRAME_CTRL_CHECKSUM_EN
//   - Adds port out_sum = sum of the frame's accepted bytes mod 2**DATA_W.
//   - The accumulator clears on reset and when frame_done fires.
//   - out_sum is valid, and held, from the frame_done cycle until the first accept of the next frame.
//  Without the macro: the out_sum port and the accumulator do not exist; all other behaviour is identical.
// STRUCTURE
//  Package dpram_frame_pkg:
//   - state encoding localparams S_WR=2'd0, S_GAP=2'd1, S_RD=2'd2, S_DRAIN=2'd3
//   - default widths DATA_W=8, ADDR_W=8
//  One sub-module: dpram_rd_pipe, an RD_LAT-deep shift register of the issue flag.
//   - Its output drives out_valid and the drain-empty detect.
//  The FSM and counters stay in the top module. The dpram is instantiated by the parent, not inside this block.
// TESTING (bench instantiates real dpram, FRAME_LEN=16, RD_LAT=1, 20 ns clock)
//  1 Reset, then stream data=255-i for i=0..15 with continuous in_valid
//    -> wren high for 16 cycles, wraddress 0..15;
//    -> out_valid for 16 consecutive cycles, out_data 255..240;
//    -> frame_done pulses once.
//  2 in_valid toggled 1/0 every cycle
//    -> exactly 16 writes at the correct addresses; read-back identical to scenario 1.
//  3 in_valid held high during S_RD with data 0x00
//    -> in_ready=0 and wren=0 throughout; frame 1 reads back unchanged;
//    -> the next frame starts at wraddress 0.
//  4 Rst_n asserted at the 5th read cycle
//    -> out_valid, wren, in_ready and rdaddress all 0 immediately;
//    -> after release, in_ready=1 and a new frame writes from address 0.
//  5 FRAME_LEN=1, RD_LAT=2, input 0xA5
//    -> one write to address 0; S_GAP cycle; out_valid 2 cycles after rdaddress=0, out_data=0xA5.
//  6 With DPRAM_FRAME_CTRL_CHECKSUM_EN, data 255..240
//    -> out_sum=0x78 at frame_done; held until the next accept.

Source files
------------

// File: rtl/dpram_frame_pkg.sv
// Shared types and default widths for the dual-port RAM frame sequencer.
package dpram_frame_pkg;

  typedef enum logic [1:0] {
    S_WR    = 2'd0,
    S_GAP   = 2'd1,
    S_RD    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-issue delay line: one flag per issued rdaddress, delayed STAGES clocks to line up with q.
module dpram_rd_pipe
  import dpram_frame_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic issue,
  output logic vld,
  output logic pending
);

  logic [STAGES-1:0] vld_p;

  // pending covers every stage except the output one, so it reads "empty after this edge"
  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) vld_p <= '0;
        else        vld_p <= issue;
      end
      assign pending = 1'b0;
    end else begin : g_multi
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) vld_p <= '0;
        else        vld_p <= {vld_p[STAGES-2:0], issue};
      end
      assign pending = |vld_p[STAGES-2:0];
    end
  endgenerate

  assign vld = vld_p[STAGES-1];

endmodule

// File: rtl/dpram_frame_ctrl.sv
// Single-buffer frame sequencer for an external dual-port RAM: write a frame, then read it out.
// Optional frame checksum output enabled by `define DPRAM_FRAME_CTRL_CHECKSUM_EN.
module dpram_frame_ctrl
  import dpram_frame_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_LEN = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_done
`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] out_sum
`endif
);

  localparam logic [ADDR_W:0] LAST_WR   = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic              rd_issue;
  logic              pipe_pending;
  logic              accept;
  logic              drain_done;

  assign accept     = (state == S_WR) && in_valid && in_ready;
  assign drain_done = (state == S_DRAIN) && !pipe_pending;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_WR;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      in_ready   <= 1'b0;
      wren       <= 1'b0;
      wraddress  <= '0;
      data       <= '0;
      rdaddress  <= '0;
      rd_issue   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wren       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_WR: begin
          in_ready <= 1'b1;
          if (accept) begin
            wren      <= 1'b1;
            wraddress <= wr_cnt[ADDR_W-1:0];
            data      <= in_data;
            wr_cnt    <= wr_cnt + CNT_ONE;
            if (wr_cnt == LAST_WR) begin
              state    <= S_GAP;
              in_ready <= 1'b0;
            end
          end
        end
        // one idle cycle lets the final write land before address 0 is read
        S_GAP: begin
          state     <= S_RD;
          rdaddress <= '0;
          rd_issue  <= 1'b1;
          rd_cnt    <= CNT_ONE;
        end
        S_RD: begin
          if (rd_cnt == FRAME_CNT) begin
            state    <= S_DRAIN;
            rd_issue <= 1'b0;
          end else begin
            rdaddress <= rd_cnt[ADDR_W-1:0];
            rd_cnt    <= rd_cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (!pipe_pending) begin
            frame_done <= 1'b1;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            state      <= S_WR;
          end
        end
        default: state <= S_WR;
      endcase
    end
  end

  dpram_rd_pipe #(
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .issue   (rd_issue),
    .vld     (out_valid),
    .pending (pipe_pending)
  );

  assign out_data = out_valid ? q : '0;

`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] sum_acc;

  // out_sum latches the finished frame's sum; the accumulator restarts for the next frame
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_acc <= '0;
      out_sum <= '0;
    end else if (drain_done) begin
      out_sum <= sum_acc;
      sum_acc <= '0;
    end else if (accept) begin
      sum_acc <= sum_acc + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_frame_ctrl.sv
// Scoreboard bench for dpram_frame_ctrl with behavioural dual-port RAMs (16/1 and 1/2 configurations).
module tb_dpram_frame_ctrl;

  logic       Clk;
  logic       Rst_n;

  logic [7:0] in_data_a, wraddress_a, data_a, rdaddress_a, q_a, out_data_a;
  logic       in_valid_a, in_ready_a, wren_a, out_valid_a, frame_done_a;
  logic [7:0] in_data_b, wraddress_b, data_b, rdaddress_b, q_b, q_b1, out_data_b;
  logic       in_valid_b, in_ready_b, wren_b, out_valid_b, frame_done_b;
`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
  logic [7:0] out_sum_a, out_sum_b;
`endif

  logic [7:0]  mem_a [0:255];
  logic [7:0]  mem_b [0:255];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  rd_q_b [$];
  logic [15:0] mon_exp_w;
  logic [7:0]  mon_exp_r;
  bit          mon_en;
  int          checks;
  int          errors;

  dpram_frame_ctrl #(.DATA_W(8), .ADDR_W(8), .FRAME_LEN(16), .RD_LAT(1)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .wraddress(wraddress_a), .data(data_a), .wren(wren_a), .rdaddress(rdaddress_a), .q(q_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .frame_done(frame_done_a)
`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
    , .out_sum(out_sum_a)
`endif
  );

  dpram_frame_ctrl #(.DATA_W(8), .ADDR_W(8), .FRAME_LEN(1), .RD_LAT(2)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .wraddress(wraddress_b), .data(data_b), .wren(wren_b), .rdaddress(rdaddress_b), .q(q_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .frame_done(frame_done_b)
`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
    , .out_sum(out_sum_b)
`endif
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Behavioural RAMs: 1-cycle read for dut_a, 2-cycle read for dut_b
  always @(posedge Clk) begin
    if (wren_a) mem_a[wraddress_a] <= data_a;
    q_a <= mem_a[rdaddress_a];
    if (wren_b) mem_b[wraddress_b] <= data_b;
    q_b1 <= mem_b[rdaddress_b];
    q_b  <= q_b1;
  end

  // Scoreboard monitor for dut_a writes and read-back
  always @(negedge Clk) begin
    if (mon_en) begin
      if (wren_a) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got addr=%0d data=%02h required=no write", wraddress_a, data_a);
        end else begin
          mon_exp_w = wr_q.pop_front();
          if ({wraddress_a, data_a} !== mon_exp_w)
            begin errors++; $display("FAIL write got addr=%0d data=%02h required addr=%0d data=%02h",
                                     wraddress_a, data_a, mon_exp_w[15:8], mon_exp_w[7:0]); end
        end
      end
      if (out_valid_a) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected got out_data=%02h required=no valid", out_data_a);
        end else begin
          mon_exp_r = rd_q.pop_front();
          if (out_data_a !== mon_exp_r)
            begin errors++; $display("FAIL read got out_data=%02h required=%02h", out_data_a, mon_exp_r); end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] base, input bit dec, input bit toggle, input bit hold);
    int i = 0;
    int cyc = 0;
    bit on = 1'b1;
    while (i < 16 && cyc < 200) begin
      @(posedge Clk); #1;
      in_valid_a = on;
      in_data_a  = dec ? 8'(base - 8'(i)) : base;
      if (toggle) on = ~on;
      @(negedge Clk);
      if (in_valid_a && in_ready_a) begin
        wr_q.push_back({8'(i), in_data_a});
        rd_q.push_back(in_data_a);
        i++;
      end
      cyc++;
    end
    @(posedge Clk); #1;
    if (hold) in_data_a = 8'h00;
    else      in_valid_a = 1'b0;
    checks++;
    if (i != 16) begin errors++; $display("FAIL send_frame accepted=%0d required=16", i); end
  endtask

  task automatic observe(input int ncyc, output int nvalid, output int ndone, output int span,
                         output int nwr, output int nrdy);
    int first = -1;
    int last = -1;
    nvalid = 0; ndone = 0; nwr = 0; nrdy = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      if (out_valid_a) begin
        if (first < 0) first = c;
        last = c;
        nvalid++;
      end
      if (frame_done_a) ndone++;
      if (wren_a) nwr++;
      if (in_ready_a) nrdy++;
    end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; mon_en = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0; in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b required=0", in_ready_a); end
    checks++; if (wren_a !== 1'b0) begin errors++; $display("FAIL reset_wren got=%0b required=0", wren_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b required=0", out_valid_a); end
    checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%0b required=0", frame_done_a); end
    checks++; if ({wraddress_a, data_a, rdaddress_a, out_data_a} !== 32'h0)
      begin errors++; $display("FAIL reset_buses got=%08h required=00000000", {wraddress_a, data_a, rdaddress_a, out_data_a}); end
    @(posedge Clk); #1; Rst_n = 1'b1;
    @(negedge Clk);
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got=%0b required=0", in_ready_a); end
    @(negedge Clk);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%0b required=1", in_ready_a); end
    mon_en = 1'b1;
  endtask

  task automatic test_continuous();
    int nv, nd, sp, nw, nr;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    observe(19, nv, nd, sp, nw, nr);
    checks++; if (nv !== 16) begin errors++; $display("FAIL cont_valid_count got=%0d required=16", nv); end
    checks++; if (sp !== 16) begin errors++; $display("FAIL cont_valid_span got=%0d required=16", sp); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL cont_frame_done got=%0d required=1", nd); end
    checks++; if (nw !== 1) begin errors++; $display("FAIL cont_writes_after_accept got=%0d required=1", nw); end
    @(negedge Clk);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL cont_in_ready_after_done got=%0b required=1", in_ready_a); end
    checks++; if (wr_q.size() + rd_q.size() !== 0)
      begin errors++; $display("FAIL cont_scoreboard_left got=%0d required=0", wr_q.size() + rd_q.size()); end
  endtask

  task automatic test_gappy();
    int nv, nd, sp, nw, nr;
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    observe(19, nv, nd, sp, nw, nr);
    checks++; if (nv !== 16) begin errors++; $display("FAIL gap_valid_count got=%0d required=16", nv); end
    checks++; if (sp !== 16) begin errors++; $display("FAIL gap_valid_span got=%0d required=16", sp); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL gap_frame_done got=%0d required=1", nd); end
    @(negedge Clk);
    checks++; if (wr_q.size() + rd_q.size() !== 0)
      begin errors++; $display("FAIL gap_scoreboard_left got=%0d required=0", wr_q.size() + rd_q.size()); end
  endtask

  task automatic test_hold_during_read();
    int nv, nd, sp, nw, nr;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    observe(19, nv, nd, sp, nw, nr);
    checks++; if (nr !== 0) begin errors++; $display("FAIL hold_in_ready_cycles got=%0d required=0", nr); end
    checks++; if (nw !== 1) begin errors++; $display("FAIL hold_writes got=%0d required=1", nw); end
    checks++; if (nv !== 16) begin errors++; $display("FAIL hold_valid_count got=%0d required=16", nv); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL hold_frame_done got=%0d required=1", nd); end
    // in_valid is still high: the next frame of zeros must begin at address 0
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    observe(19, nv, nd, sp, nw, nr);
    checks++; if (nd !== 1) begin errors++; $display("FAIL hold_next_frame_done got=%0d required=1", nd); end
    @(negedge Clk);
    checks++; if (wr_q.size() + rd_q.size() !== 0)
      begin errors++; $display("FAIL hold_scoreboard_left got=%0d required=0", wr_q.size() + rd_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    int nv, nd, sp, nw, nr;
    send_frame(8'h80, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge Clk);
    #1;
    checks++; if (rdaddress_a !== 8'd4) begin errors++; $display("FAIL mid_rdaddress got=%0d required=4", rdaddress_a); end
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL mid_out_valid got=%0b required=1", out_valid_a); end
    mon_en = 1'b0;
    Rst_n = 1'b0;
    #1;
    checks++; if ({out_valid_a, wren_a, in_ready_a} !== 3'b000)
      begin errors++; $display("FAIL mid_reset_ctrl got=%03b required=000", {out_valid_a, wren_a, in_ready_a}); end
    checks++; if (rdaddress_a !== 8'd0) begin errors++; $display("FAIL mid_reset_rdaddress got=%0d required=0", rdaddress_a); end
    wr_q.delete(); rd_q.delete();
    repeat (2) @(posedge Clk);
    #1; Rst_n = 1'b1;
    @(negedge Clk); @(negedge Clk);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got=%0b required=1", in_ready_a); end
    mon_en = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    observe(19, nv, nd, sp, nw, nr);
    checks++; if (nv !== 16) begin errors++; $display("FAIL mid_new_valid_count got=%0d required=16", nv); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL mid_new_frame_done got=%0d required=1", nd); end
    @(negedge Clk);
    checks++; if (wr_q.size() + rd_q.size() !== 0)
      begin errors++; $display("FAIL mid_scoreboard_left got=%0d required=0", wr_q.size() + rd_q.size()); end
  endtask

  task automatic test_single_byte();
    int widx = -1;
    int vidx = -1;
    int didx = -1;
    int nw = 0;
    int nv = 0;
    int nd = 0;
    logic [7:0] exp_b;
    @(posedge Clk); #1;
    in_valid_b = 1'b1; in_data_b = 8'hA5;
    rd_q_b.push_back(8'hA5);
    @(negedge Clk);
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%0b required=1", in_ready_b); end
    @(posedge Clk); #1;
    in_valid_b = 1'b0; in_data_b = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (wren_b) begin
        nw++; widx = c;
        checks++;
        if ({wraddress_b, data_b} !== 16'h00A5)
          begin errors++; $display("FAIL single_write got=%04h required=00a5", {wraddress_b, data_b}); end
      end
      if (out_valid_b) begin
        nv++; vidx = c;
        checks++;
        if (rd_q_b.size() == 0) begin
          errors++; $display("FAIL single_read_unexpected got=%02h required=no valid", out_data_b);
        end else begin
          exp_b = rd_q_b.pop_front();
          if (out_data_b !== exp_b) begin errors++; $display("FAIL single_read got=%02h required=%02h", out_data_b, exp_b); end
        end
      end
      if (frame_done_b) begin nd++; didx = c; end
    end
    checks++; if (nw !== 1) begin errors++; $display("FAIL single_write_count got=%0d required=1", nw); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL single_valid_count got=%0d required=1", nv); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL single_done_count got=%0d required=1", nd); end
    checks++; if (vidx !== widx + 3) begin errors++; $display("FAIL single_latency got=%0d required=%0d", vidx, widx + 3); end
    checks++; if (didx !== vidx + 1) begin errors++; $display("FAIL single_done_pos got=%0d required=%0d", didx, vidx + 1); end
  endtask

`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] exp_sum = 8'h00;
    bit found = 1'b0;
    for (int i = 0; i < 16; i++) exp_sum = exp_sum + 8'(255 - i);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (frame_done_a) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL sum_frame_done got=none required=pulse"); end
    checks++; if (out_sum_a !== exp_sum) begin errors++; $display("FAIL sum_at_done got=%02h required=%02h", out_sum_a, exp_sum); end
    repeat (5) @(negedge Clk);
    checks++; if (out_sum_a !== exp_sum) begin errors++; $display("FAIL sum_held got=%02h required=%02h", out_sum_a, exp_sum); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_continuous();
    test_gappy();
    test_hold_during_read();
    test_reset_mid_read();
`ifdef DPRAM_FRAME_CTRL_CHECKSUM_EN
    test_checksum();
`endif
    test_single_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
